mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage_access_fsm.sv | 88 ++++++++
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, watchdog
// limit and the data-memory access FSM state encoding.
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 16;   // data word width
    localparam int MEM_ADDR_WIDTH = 8;    // data-memory address width
    localparam int MEM_REG_WIDTH  = 4;    // register-index width
    localparam int MEM_TMO_CYCLES = 255;  // watchdog limit (cycles)

    // Data-memory access FSM states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_e;

endpackage : mem_pkg

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port of the MEM stage.
// master: the MEM stage (issues requests); slave: the data memory.
interface mem_stage_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

    logic                  dm_req_o;
    logic                  dm_we_o;
    logic [ADDR_WIDTH-1:0] dm_addr_o;
    logic [DATA_WIDTH-1:0] dm_wdata_o;
    logic [DATA_WIDTH-1:0] dm_rdata_i;
    logic                  dm_ack_i;

    modport master (
        output dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
        input  dm_rdata_i, dm_ack_i
    );

    modport slave (
        input  dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
        output dm_rdata_i, dm_ack_i
    );

endinterface : mem_stage_if

// File: rtl/mem_stage_access_fsm.sv
// Data-memory access sequencer for the MEM stage: drives the request,
// raises the pipeline stall while an access is outstanding, and reports the
// cycle in which the access completes.
// Optional feature: MEM_STAGE_TIMEOUT_EN adds a WAIT-state watchdog that
// completes a hung access after TMO_CYCLES stall cycles and sets a sticky
// error flag until reset.
module mem_access_fsm
    import mem_pkg::*;
#(
    parameter int TMO_CYCLES = MEM_TMO_CYCLES
) (
    input  logic clk,
    input  logic rst,        // synchronous, active-low
    input  logic access,     // EX/MEM holds a load or store
    input  logic ack,        // data-memory acknowledge
    output logic req,        // data-memory request
    output logic stall,      // access pending, freeze IF..EX/MEM
    output logic done,       // access completes this cycle
    output logic tmoFire     // completion forced by the watchdog
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    output logic dmErr       // sticky watchdog error
`endif
);

    memState_e state;
    memState_e nextState;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0] wdCnt;
    logic       errQ;

    // wdCnt holds the number of WAIT cycles already spent, so the watchdog
    // fires in the WAIT cycle that brings the stall total to TMO_CYCLES.
    assign tmoFire = rst && (state == WAIT) && !ack
                     && (wdCnt == 8'(TMO_CYCLES - 1));

    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdCnt <= '0;
            errQ  <= 1'b0;
        end else begin
            if ((state == WAIT) && !ack && !tmoFire) wdCnt <= wdCnt + 8'd1;
            else                                     wdCnt <= '0;
            if (tmoFire) errQ <= 1'b1;
        end
    end

    assign dmErr = errQ;
`else
    assign tmoFire = 1'b0;
`endif

    // Next-state and request/stall decode
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        nextState = state;
        req       = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req = access;
                if (access && !ack) nextState = WAIT;
            end
            WAIT: begin
                req = 1'b1;
                if (ack || tmoFire) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // The request is held off while reset is asserted.
        if (!rst) req = 1'b0;
        stall = req && !(ack || tmoFire);
        done  = req && (ack || tmoFire);
    end

endmodule : mem_access_fsm

// File: rtl/mem_stage.sv
// MEM pipeline stage: result forwarding mux, branch resolution, data-memory
// port drive and the MEM/WB pipeline register. Access sequencing lives in
// mem_access_fsm.
// Optional feature: MEM_STAGE_TIMEOUT_EN (watchdog on hung data-memory
// accesses, adds the dm_err_o output).
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int REG_WIDTH  = MEM_REG_WIDTH,
    parameter int TMO_CYCLES = MEM_TMO_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,            // synchronous, active-low

    // EX/MEM register contents
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [DATA_WIDTH-1:0] imm8M_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic [DATA_WIDTH-1:0] WriteRegM_i,    // low REG_WIDTH bits used
    input  logic                  RegWriteM_i,
    input  logic                  BranchM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MovM_i,
    input  logic                  flush_MEM_WB_i,

    // Data-memory port
    mem_stage_if.master           dmBus,

    // MEM-stage results
    output logic [DATA_WIDTH-1:0] WBResultM_o,
    output logic                  mem_stall_o,
    output logic                  BranchTakenM_o,
    output logic [ADDR_WIDTH-1:0] BranchTargetM_o,

    // MEM/WB register
`ifdef MEM_STAGE_TIMEOUT_EN
    output logic                  dm_err_o,
`endif
    output logic [DATA_WIDTH-1:0] ReadDataW_o,
    output logic [DATA_WIDTH-1:0] alu_outW_o,
    output logic [DATA_WIDTH-1:0] WBResultW_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic                  RegWriteW_o,
    output logic                  MemToRegW_o
);

    logic                  access;
    logic                  isRead;
    logic                  accessDone;
    logic                  tmoFire;
    logic                  fsmReq;
    logic [DATA_WIDTH-1:0] readDataM;
    logic                  unusedWriteRegBits;

    assign access = MemReadM_i | MemWriteM_i;
    // A combined read+write is a write; its read data is discarded.
    assign isRead = MemReadM_i & ~MemWriteM_i;

    // Only the low REG_WIDTH bits of the destination field are meaningful.
    assign unusedWriteRegBits = ^WriteRegM_i[DATA_WIDTH-1:REG_WIDTH];

    mem_access_fsm #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_access_fsm (
        .clk     (clk),
        .rst     (rst),
        .access  (access),
        .ack     (dmBus.dm_ack_i),
        .req     (fsmReq),
        .stall   (mem_stall_o),
        .done    (accessDone),
        .tmoFire (tmoFire)
`ifdef MEM_STAGE_TIMEOUT_EN
        ,
        .dmErr   (dm_err_o)
`endif
    );

    // Data-memory port, driven straight from EX/MEM
    assign dmBus.dm_req_o   = fsmReq;
    assign dmBus.dm_we_o    = MemWriteM_i;
    assign dmBus.dm_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
    assign dmBus.dm_wdata_o = WriteDataM_i;

    // Forwarded result and branch resolution
    assign WBResultM_o     = MovM_i ? imm8M_i : alu_outM_i;
    assign BranchTakenM_o  = BranchM_i & (alu_outM_i == '0);
    assign BranchTargetM_o = PCM_i + imm8M_i[ADDR_WIDTH-1:0];

    // Load data is captured only in the cycle the read completes; a watchdog
    // completion returns all-ones so software can spot the failed load.
    assign readDataM = (isRead && accessDone)
                       ? (tmoFire ? '1 : dmBus.dm_rdata_i)
                       : '0;

    // MEM/WB register: bubble on reset, flush or stall, else capture
    always_ff @(posedge clk) begin
        // NOTE: the pipeline register is fully reset because WB consumes
        // RegWrite/MemToReg as control; stale values would commit garbage.
        if (!rst || flush_MEM_WB_i || mem_stall_o) begin
            ReadDataW_o <= '0;
            alu_outW_o  <= '0;
            WBResultW_o <= '0;
            WriteRegW_o <= '0;
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
        end else begin
            ReadDataW_o <= readDataM;
            alu_outW_o  <= alu_outM_i;
            WBResultW_o <= WBResultM_o;
            WriteRegW_o <= WriteRegM_i[REG_WIDTH-1:0];
            RegWriteW_o <= RegWriteM_i;
            MemToRegW_o <= MemToRegM_i;
        end
    end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load/store handshakes,
// mov/branch logic, flush and reset priority, and (when built with
// MEM_STAGE_TIMEOUT_EN) the watchdog.
module tb_mem_stage;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] PCM;
    logic [DW-1:0] WriteDataM, imm8M, alu_outM, WriteRegM;
    logic          RegWriteM, BranchM, MemReadM, MemWriteM, MemToRegM, MovM;
    logic          flush;

    logic [DW-1:0] WBResultM;
    logic          stall;
    logic          branchTaken;
    logic [AW-1:0] branchTarget;
    logic [DW-1:0] ReadDataW, alu_outW, WBResultW;
    logic [RW-1:0] WriteRegW;
    logic          RegWriteW, MemToRegW;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic          dmErr;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    mem_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dmBus ();

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .PCM_i           (PCM),
        .WriteDataM_i    (WriteDataM),
        .imm8M_i         (imm8M),
        .alu_outM_i      (alu_outM),
        .WriteRegM_i     (WriteRegM),
        .RegWriteM_i     (RegWriteM),
        .BranchM_i       (BranchM),
        .MemReadM_i      (MemReadM),
        .MemWriteM_i     (MemWriteM),
        .MemToRegM_i     (MemToRegM),
        .MovM_i          (MovM),
        .flush_MEM_WB_i  (flush),
        .dmBus           (dmBus),
        .WBResultM_o     (WBResultM),
        .mem_stall_o     (stall),
        .BranchTakenM_o  (branchTaken),
        .BranchTargetM_o (branchTarget),
`ifdef MEM_STAGE_TIMEOUT_EN
        .dm_err_o        (dmErr),
`endif
        .ReadDataW_o     (ReadDataW),
        .alu_outW_o      (alu_outW),
        .WBResultW_o     (WBResultW),
        .WriteRegW_o     (WriteRegW),
        .RegWriteW_o     (RegWriteW),
        .MemToRegW_o     (MemToRegW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        PCM              = '0;
        WriteDataM       = '0;
        imm8M            = '0;
        alu_outM         = '0;
        WriteRegM        = '0;
        RegWriteM        = 1'b0;
        BranchM          = 1'b0;
        MemReadM         = 1'b0;
        MemWriteM        = 1'b0;
        MemToRegM        = 1'b0;
        MovM             = 1'b0;
        flush            = 1'b0;
        dmBus.dm_ack_i   = 1'b0;
        dmBus.dm_rdata_i = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset: request held off, combinational paths still follow ----
        rst = 1'b0;
        clearInputs();
        MemReadM  = 1'b1;
        RegWriteM = 1'b1;
        alu_outM  = 16'h0033;
        #1;
        check("rst_req",   dmBus.dm_req_o, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_addr",  dmBus.dm_addr_o, 8'h33);
        tick();
        tick();
        check("rst_ReadDataW", ReadDataW, 16'h0000);
        check("rst_alu_outW",  alu_outW, 16'h0000);
        check("rst_RegWriteW", RegWriteW, 1'b0);
        check("rst_MemToRegW", MemToRegW, 1'b0);
        rst = 1'b1;
        clearInputs();
        #1;
        check("idle_req", dmBus.dm_req_o, 1'b0);

        // ---- zero-wait load ----
        MemReadM         = 1'b1;
        MemToRegM        = 1'b1;
        RegWriteM        = 1'b1;
        alu_outM         = 16'h0010;
        WriteRegM        = 16'h0005;
        dmBus.dm_rdata_i = 16'hBEEF;
        dmBus.dm_ack_i   = 1'b1;
        #1;
        check("ld_req",   dmBus.dm_req_o, 1'b1);
        check("ld_stall", stall, 1'b0);
        check("ld_addr",  dmBus.dm_addr_o, 8'h10);
        check("ld_we",    dmBus.dm_we_o, 1'b0);
        tick();
        check("ld_ReadDataW", ReadDataW, 16'hBEEF);
        check("ld_MemToRegW", MemToRegW, 1'b1);
        check("ld_RegWriteW", RegWriteW, 1'b1);
        check("ld_WriteRegW", WriteRegW, 4'h5);
        check("ld_WBResultW", WBResultW, 16'h0010);
        clearInputs();

        // ---- store acked after 3 stall cycles ----
        // RegWriteM is set so the stall bubble is observable on RegWriteW.
        MemWriteM        = 1'b1;
        RegWriteM        = 1'b1;
        alu_outM         = 16'h0020;
        WriteDataM       = 16'h1234;
        dmBus.dm_rdata_i = 16'hAAAA;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("st_stall%0d", i), stall, 1'b1);
            check($sformatf("st_we%0d", i),    dmBus.dm_we_o, 1'b1);
            check($sformatf("st_addr%0d", i),  dmBus.dm_addr_o, 8'h20);
            check($sformatf("st_wdata%0d", i), dmBus.dm_wdata_o, 16'h1234);
            tick();
            check($sformatf("st_RegWriteW%0d", i), RegWriteW, 1'b0);
            check($sformatf("st_alu_outW%0d", i),  alu_outW, 16'h0000);
        end
        dmBus.dm_ack_i = 1'b1;
        #1;
        check("st_ack_stall", stall, 1'b0);
        check("st_ack_req",   dmBus.dm_req_o, 1'b1);
        tick();
        check("st_alu_outW",  alu_outW, 16'h0020);
        check("st_RegWriteW", RegWriteW, 1'b1);
        check("st_ReadDataW", ReadDataW, 16'h0000);
        clearInputs();

        // ---- read+write together behaves as a write ----
        MemReadM         = 1'b1;
        MemWriteM        = 1'b1;
        MemToRegM        = 1'b1;
        alu_outM         = 16'h0044;
        dmBus.dm_rdata_i = 16'h5555;
        dmBus.dm_ack_i   = 1'b1;
        #1;
        check("rw_we", dmBus.dm_we_o, 1'b1);
        tick();
        check("rw_ReadDataW", ReadDataW, 16'h0000);
        clearInputs();

        // ---- mov selects the immediate ----
        MovM     = 1'b1;
        imm8M    = 16'h0042;
        alu_outM = 16'h0007;
        #1;
        check("mov_WBResultM", WBResultM, 16'h0042);
        tick();
        check("mov_WBResultW", WBResultW, 16'h0042);
        check("mov_alu_outW",  alu_outW, 16'h0007);
        MovM = 1'b0;
        #1;
        check("alu_WBResultM", WBResultM, 16'h0007);
        clearInputs();

        // ---- branch resolution with target wrap ----
        BranchM  = 1'b1;
        alu_outM = 16'h0000;
        PCM      = 8'hF0;
        imm8M    = 16'h0020;
        #1;
        check("br_taken",  branchTaken, 1'b1);
        check("br_target", branchTarget, 8'h10);
        alu_outM = 16'h0001;
        #1;
        check("br_nz_taken", branchTaken, 1'b0);
        BranchM  = 1'b0;
        alu_outM = 16'h0000;
        #1;
        check("br_off_taken", branchTaken, 1'b0);
        clearInputs();

        // ---- stray ack without a request is ignored ----
        dmBus.dm_ack_i   = 1'b1;
        dmBus.dm_rdata_i = 16'h1111;
        #1;
        check("stray_req",   dmBus.dm_req_o, 1'b0);
        check("stray_stall", stall, 1'b0);
        tick();
        dmBus.dm_ack_i = 1'b0;
        #1;
        check("stray_req_after", dmBus.dm_req_o, 1'b0);
        check("stray_ReadDataW", ReadDataW, 16'h0000);
        clearInputs();

        // ---- flush and ack together in WAIT: flush wins, FSM idles ----
        MemReadM  = 1'b1;
        RegWriteM = 1'b1;
        alu_outM  = 16'h0050;
        #1;
        check("fl_stall_idle", stall, 1'b1);
        tick();
        dmBus.dm_ack_i   = 1'b1;
        dmBus.dm_rdata_i = 16'hCAFE;
        flush            = 1'b1;
        #1;
        check("fl_stall_ack", stall, 1'b0);
        tick();
        check("fl_ReadDataW", ReadDataW, 16'h0000);
        check("fl_RegWriteW", RegWriteW, 1'b0);
        clearInputs();
        #1;
        check("fl_req_idle", dmBus.dm_req_o, 1'b0);

        // ---- reset asserted in WAIT cycle 2 ----
        MemReadM  = 1'b1;
        RegWriteM = 1'b1;
        alu_outM  = 16'h0060;
        tick();
        tick();
        check("rw2_req",   dmBus.dm_req_o, 1'b1);
        check("rw2_stall", stall, 1'b1);
        rst              = 1'b0;
        dmBus.dm_ack_i   = 1'b1;
        dmBus.dm_rdata_i = 16'hBEEF;
        #1;
        check("rw2_rst_req",   dmBus.dm_req_o, 1'b0);
        check("rw2_rst_stall", stall, 1'b0);
        tick();
        rst = 1'b1;
        clearInputs();
        #1;
        check("rw2_after_req",   dmBus.dm_req_o, 1'b0);
        check("rw2_after_stall", stall, 1'b0);
        check("rw2_ReadDataW",   ReadDataW, 16'h0000);
        check("rw2_RegWriteW",   RegWriteW, 1'b0);
        check("rw2_alu_outW",    alu_outW, 16'h0000);

`ifdef MEM_STAGE_TIMEOUT_EN
        // ---- watchdog completes a load that is never acked ----
        begin
            int nStall;
            nStall = 0;
            check("tmo_err_init", dmErr, 1'b0);
            MemReadM  = 1'b1;
            MemToRegM = 1'b1;
            alu_outM  = 16'h0070;
            #1;
            while (stall && nStall < 400) begin
                nStall++;
                tick();
            end
            check("tmo_stall_cycles", nStall, 255);
            tick();
            check("tmo_ReadDataW", ReadDataW, 16'hFFFF);
            check("tmo_err",       dmErr, 1'b1);
            clearInputs();
            tick();
            tick();
            check("tmo_err_held", dmErr, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule : tb_mem_stage
